// File: rtl/pong_match_controller_if.sv
// Pong match controller bundle: game/display inputs in, match status out.
// Adds hi_tens/hi_ones when PONG_HISCORE_EN is defined.
interface pong_match_controller_if;
  logic       start;
  logic       hit;
  logic       miss;
  logic       vsync;
  logic       ball_enable;
  logic       serve;
  logic       game_over;
  logic [3:0] score_tens;
  logic [3:0] score_ones;
  logic [2:0] lives_left;
  logic [2:0] state;
`ifdef PONG_HISCORE_EN
  logic [3:0] hi_tens;
  logic [3:0] hi_ones;

  modport master (
    output start, hit, miss, vsync,
    input  ball_enable, serve, game_over, score_tens, score_ones,
           lives_left, state, hi_tens, hi_ones
  );
  modport slave (
    input  start, hit, miss, vsync,
    output ball_enable, serve, game_over, score_tens, score_ones,
           lives_left, state, hi_tens, hi_ones
  );
`else
  modport master (
    output start, hit, miss, vsync,
    input  ball_enable, serve, game_over, score_tens, score_ones,
           lives_left, state
  );
  modport slave (
    input  start, hit, miss, vsync,
    output ball_enable, serve, game_over, score_tens, score_ones,
           lives_left, state
  );
`endif
endinterface

// File: rtl/pong_match_controller.sv
// Pong match FSM (score, lives, serve delay, game over); all outputs registered, 1-cycle latency, no backpressure.
// Optional high-score register enabled by PONG_HISCORE_EN.
module pong_match_controller #(
  parameter int LIVES        = 3,
  parameter int SERVE_FRAMES = 60
) (
  input  logic                     Clock,
  input  logic                     Reset,
  pong_match_controller_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_OVER  = 3'd3
  } state_t;

  localparam logic [2:0] LIVES_INIT = 3'(LIVES);
  localparam logic [7:0] FRAMES_END = 8'(SERVE_FRAMES);

  state_t     state_q, state_d;
  logic       start_prev_q, start_prev_d;
  logic       hit_prev_q, hit_prev_d;
  logic       miss_prev_q, miss_prev_d;
  logic       vsync_prev_q, vsync_prev_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic [2:0] lives_q, lives_d;
  logic       ball_enable_q, ball_enable_d;
  logic       serve_q, serve_d;
  logic       game_over_q, game_over_d;

  logic       start_rise, hit_rise, miss_rise, vsync_rise;
  logic [7:0] frame_inc;

  assign start_rise = bus.start & ~start_prev_q;
  assign hit_rise   = bus.hit   & ~hit_prev_q;
  assign miss_rise  = bus.miss  & ~miss_prev_q;
  assign vsync_rise = bus.vsync & ~vsync_prev_q;
  assign frame_inc  = frame_cnt_q + 8'd1;

  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    tens_d       = tens_q;
    ones_d       = ones_q;
    lives_d      = lives_q;
    serve_d      = 1'b0;
    start_prev_d = bus.start;
    hit_prev_d   = bus.hit;
    miss_prev_d  = bus.miss;
    vsync_prev_d = bus.vsync;

    case (state_q)
      ST_IDLE: begin
        tens_d  = 4'd0;
        ones_d  = 4'd0;
        lives_d = LIVES_INIT;
        if (start_rise) begin
          state_d     = ST_SERVE;
          frame_cnt_d = 8'd0;
        end
      end
      ST_SERVE: begin
        if (vsync_rise) begin
          frame_cnt_d = frame_inc;
          if (frame_inc == FRAMES_END) begin
            state_d = ST_PLAY;
            serve_d = 1'b1;
          end
        end
      end
      ST_PLAY: begin
        // A miss on the same edge as a hit swallows the hit.
        if (miss_rise) begin
          if (lives_q > 3'd1) begin
            lives_d     = lives_q - 3'd1;
            state_d     = ST_SERVE;
            frame_cnt_d = 8'd0;
          end else begin
            lives_d = 3'd0;
            state_d = ST_OVER;
          end
        end else if (hit_rise && !(tens_q == 4'd9 && ones_q == 4'd9)) begin
          if (ones_q == 4'd9) begin
            ones_d = 4'd0;
            tens_d = tens_q + 4'd1;
          end else begin
            ones_d = ones_q + 4'd1;
          end
        end
      end
      ST_OVER: begin
        if (start_rise) begin
          state_d     = ST_SERVE;
          tens_d      = 4'd0;
          ones_d      = 4'd0;
          lives_d     = LIVES_INIT;
          frame_cnt_d = 8'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ball_enable_d = (state_d == ST_PLAY);
    game_over_d   = (state_d == ST_OVER);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q       <= ST_IDLE;
      start_prev_q  <= 1'b0;
      hit_prev_q    <= 1'b0;
      miss_prev_q   <= 1'b0;
      vsync_prev_q  <= 1'b0;
      frame_cnt_q   <= 8'd0;
      tens_q        <= 4'd0;
      ones_q        <= 4'd0;
      lives_q       <= LIVES_INIT;
      ball_enable_q <= 1'b0;
      serve_q       <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_prev_q  <= start_prev_d;
      hit_prev_q    <= hit_prev_d;
      miss_prev_q   <= miss_prev_d;
      vsync_prev_q  <= vsync_prev_d;
      frame_cnt_q   <= frame_cnt_d;
      tens_q        <= tens_d;
      ones_q        <= ones_d;
      lives_q       <= lives_d;
      ball_enable_q <= ball_enable_d;
      serve_q       <= serve_d;
      game_over_q   <= game_over_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.ball_enable = ball_enable_q;
  assign bus.serve       = serve_q;
  assign bus.game_over   = game_over_q;
  assign bus.score_tens  = tens_q;
  assign bus.score_ones  = ones_q;
  assign bus.lives_left  = lives_q;

`ifdef PONG_HISCORE_EN
  logic [3:0] hi_tens_q, hi_tens_d;
  logic [3:0] hi_ones_q, hi_ones_d;

  // Packed BCD digits compare correctly as a plain unsigned byte.
  always_comb begin
    hi_tens_d = hi_tens_q;
    hi_ones_d = hi_ones_q;
    if (state_q != ST_OVER && state_d == ST_OVER &&
        {tens_d, ones_d} > {hi_tens_q, hi_ones_q}) begin
      hi_tens_d = tens_d;
      hi_ones_d = ones_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      hi_tens_q <= 4'd0;
      hi_ones_q <= 4'd0;
    end else begin
      hi_tens_q <= hi_tens_d;
      hi_ones_q <= hi_ones_d;
    end
  end

  assign bus.hi_tens = hi_tens_q;
  assign bus.hi_ones = hi_ones_q;
`endif

endmodule

// File: tb/tb_pong_match_controller.sv
// Directed self-checking bench for pong_match_controller (default LIVES=3, SERVE_FRAMES=60).
module tb_pong_match_controller;

  logic Clock;
  logic Reset;
  int   checks;
  int   failures;

  pong_match_controller_if bus();

  pong_match_controller dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic step(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic vsync_pulse();
    bus.vsync = 1'b1; step(1);
    bus.vsync = 1'b0; step(1);
  endtask

  task automatic hit_pulse();
    bus.hit = 1'b1; step(1);
    bus.hit = 1'b0; step(1);
  endtask

  task automatic miss_pulse();
    bus.miss = 1'b1; step(1);
    bus.miss = 1'b0; step(1);
  endtask

  task automatic start_pulse();
    bus.start = 1'b1; step(1);
    bus.start = 1'b0; step(1);
  endtask

  task automatic serve_complete();
    repeat (60) vsync_pulse();
  endtask

  task automatic test_reset();
    Reset = 1'b1; step(2);
    Reset = 1'b0; step(1000);
    checks++;
    if (bus.state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
    checks++;
    if ({bus.score_tens, bus.score_ones} !== 8'h00) begin failures++; $display("FAIL reset_score got=%0d%0d exp=00", bus.score_tens, bus.score_ones); end
    checks++;
    if (bus.lives_left !== 3'd3) begin failures++; $display("FAIL reset_lives got=%0d exp=3", bus.lives_left); end
    checks++;
    if ({bus.ball_enable, bus.serve, bus.game_over} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {bus.ball_enable, bus.serve, bus.game_over}); end
`ifdef PONG_HISCORE_EN
    checks++;
    if ({bus.hi_tens, bus.hi_ones} !== 8'h00) begin failures++; $display("FAIL reset_hi got=%0d%0d exp=00", bus.hi_tens, bus.hi_ones); end
`endif
  endtask

  task automatic test_serve();
    start_pulse();
    checks++;
    if (bus.state !== 3'd1) begin failures++; $display("FAIL start_to_serve got=%0d exp=1", bus.state); end
    // A vsync level held high counts as a single frame.
    bus.vsync = 1'b1; step(10);
    bus.vsync = 1'b0; step(1);
    repeat (57) vsync_pulse();
    hit_pulse();
    miss_pulse();
    start_pulse();
    vsync_pulse();
    checks++;
    if (bus.state !== 3'd1 || bus.ball_enable !== 1'b0) begin failures++; $display("FAIL serve_59 got state=%0d be=%b exp state=1 be=0", bus.state, bus.ball_enable); end
    checks++;
    if ({bus.score_tens, bus.score_ones} !== 8'h00 || bus.lives_left !== 3'd3) begin failures++; $display("FAIL serve_ignores got score=%0d%0d lives=%0d exp 00 3", bus.score_tens, bus.score_ones, bus.lives_left); end
    bus.vsync = 1'b1; step(1);
    checks++;
    if (bus.serve !== 1'b1 || bus.state !== 3'd2 || bus.ball_enable !== 1'b1) begin failures++; $display("FAIL serve_60 got serve=%b state=%0d be=%b exp 1 2 1", bus.serve, bus.state, bus.ball_enable); end
    bus.vsync = 1'b0; step(1);
    checks++;
    if (bus.serve !== 1'b0) begin failures++; $display("FAIL serve_one_cycle got=%b exp=0", bus.serve); end
  endtask

  task automatic test_score();
    repeat (12) hit_pulse();
    checks++;
    if ({bus.score_tens, bus.score_ones} !== 8'h12) begin failures++; $display("FAIL score_12 got=%0d%0d exp=12", bus.score_tens, bus.score_ones); end
    bus.hit = 1'b1; step(500);
    bus.hit = 1'b0; step(1);
    checks++;
    if ({bus.score_tens, bus.score_ones} !== 8'h13) begin failures++; $display("FAIL hit_held got=%0d%0d exp=13", bus.score_tens, bus.score_ones); end
    repeat (100) hit_pulse();
    checks++;
    if ({bus.score_tens, bus.score_ones} !== 8'h99) begin failures++; $display("FAIL score_sat got=%0d%0d exp=99", bus.score_tens, bus.score_ones); end
  endtask

  task automatic test_lives();
    miss_pulse();
    checks++;
    if (bus.lives_left !== 3'd2 || bus.state !== 3'd1 || bus.ball_enable !== 1'b0) begin failures++; $display("FAIL miss_1 got lives=%0d state=%0d be=%b exp 2 1 0", bus.lives_left, bus.state, bus.ball_enable); end
    serve_complete();
    miss_pulse();
    checks++;
    if (bus.lives_left !== 3'd1 || bus.state !== 3'd1) begin failures++; $display("FAIL miss_2 got lives=%0d state=%0d exp 1 1", bus.lives_left, bus.state); end
    serve_complete();
    miss_pulse();
    checks++;
    if (bus.lives_left !== 3'd0 || bus.state !== 3'd3 || bus.game_over !== 1'b1 || bus.ball_enable !== 1'b0) begin failures++; $display("FAIL miss_3 got lives=%0d state=%0d go=%b be=%b exp 0 3 1 0", bus.lives_left, bus.state, bus.game_over, bus.ball_enable); end
    checks++;
    if ({bus.score_tens, bus.score_ones} !== 8'h99) begin failures++; $display("FAIL over_score_held got=%0d%0d exp=99", bus.score_tens, bus.score_ones); end
    miss_pulse();
    checks++;
    if (bus.lives_left !== 3'd0 || bus.state !== 3'd3) begin failures++; $display("FAIL over_no_underflow got lives=%0d state=%0d exp 0 3", bus.lives_left, bus.state); end
    start_pulse();
    checks++;
    if (bus.state !== 3'd1 || {bus.score_tens, bus.score_ones} !== 8'h00 || bus.lives_left !== 3'd3 || bus.game_over !== 1'b0) begin failures++; $display("FAIL restart got state=%0d score=%0d%0d lives=%0d go=%b exp 1 00 3 0", bus.state, bus.score_tens, bus.score_ones, bus.lives_left, bus.game_over); end
  endtask

  task automatic test_simultaneous();
    serve_complete();
    repeat (5) hit_pulse();
    bus.hit = 1'b1; bus.miss = 1'b1; step(1);
    bus.hit = 1'b0; bus.miss = 1'b0; step(1);
    checks++;
    if ({bus.score_tens, bus.score_ones} !== 8'h05 || bus.lives_left !== 3'd2 || bus.state !== 3'd1) begin failures++; $display("FAIL hit_miss_same got score=%0d%0d lives=%0d state=%0d exp 05 2 1", bus.score_tens, bus.score_ones, bus.lives_left, bus.state); end
  endtask

  task automatic test_reset_mid();
    repeat (30) vsync_pulse();
    Reset = 1'b1; step(1);
    checks++;
    if (bus.state !== 3'd0 || {bus.score_tens, bus.score_ones} !== 8'h00 || bus.lives_left !== 3'd3 || {bus.ball_enable, bus.serve, bus.game_over} !== 3'b000) begin failures++; $display("FAIL reset_mid got state=%0d score=%0d%0d lives=%0d flags=%b exp 0 00 3 000", bus.state, bus.score_tens, bus.score_ones, bus.lives_left, {bus.ball_enable, bus.serve, bus.game_over}); end
    Reset = 1'b0; step(1);
    // A stale frame count would release the ball early here.
    start_pulse();
    repeat (59) vsync_pulse();
    checks++;
    if (bus.state !== 3'd1) begin failures++; $display("FAIL reset_clears_count got=%0d exp=1", bus.state); end
  endtask

`ifdef PONG_HISCORE_EN
  task automatic play_game(input int hits);
    start_pulse();
    serve_complete();
    repeat (hits) hit_pulse();
    miss_pulse();
    serve_complete();
    miss_pulse();
    serve_complete();
    miss_pulse();
  endtask

  task automatic test_hiscore();
    Reset = 1'b1; step(1);
    Reset = 1'b0; step(1);
    play_game(7);
    checks++;
    if (bus.state !== 3'd3 || {bus.hi_tens, bus.hi_ones} !== 8'h07) begin failures++; $display("FAIL hi_game1 got state=%0d hi=%0d%0d exp 3 07", bus.state, bus.hi_tens, bus.hi_ones); end
    play_game(4);
    checks++;
    if ({bus.hi_tens, bus.hi_ones} !== 8'h07) begin failures++; $display("FAIL hi_game2 got=%0d%0d exp=07", bus.hi_tens, bus.hi_ones); end
    play_game(15);
    checks++;
    if ({bus.hi_tens, bus.hi_ones} !== 8'h15) begin failures++; $display("FAIL hi_game3 got=%0d%0d exp=15", bus.hi_tens, bus.hi_ones); end
  endtask
`endif

  initial begin
    checks    = 0;
    failures  = 0;
    Reset     = 1'b1;
    bus.start = 1'b0;
    bus.hit   = 1'b0;
    bus.miss  = 1'b0;
    bus.vsync = 1'b0;
    test_reset();
    test_serve();
    test_score();
    test_lives();
    test_simultaneous();
    test_reset_mid();
`ifdef PONG_HISCORE_EN
    test_hiscore();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
